// File: rtl/uvmt_cv32e40s_sl_mem_op_sequencer.sv
// Data-side OBI memory-operation sequencer.
// Captures granted data requests in order, tracks in-order response completion,
// and on each RVFI retire pops that instruction's accesses into numbered slots
// for the per-slot load/store trigger-match checkers.
module uvmt_cv32e40s_sl_mem_op_sequencer #(
    parameter int MAX_MEM_ACCESS = 13,
    parameter int ADDR_W         = 32,
    parameter int DEPTH          = 2*MAX_MEM_ACCESS
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  obi_req_i,
    input  logic                                  obi_gnt_i,
    input  logic [ADDR_W-1:0]                     obi_addr_i,
    input  logic                                  obi_we_i,
    input  logic                                  obi_rvalid_i,
    input  logic                                  rvfi_valid_i,
    input  logic                                  rvfi_dbg_mode_i,
    input  logic [3:0]                            rvfi_mem_cnt_i,
    output logic [MAX_MEM_ACCESS-1:0]             slot_valid_o,
    output logic [MAX_MEM_ACCESS-1:0][ADDR_W-1:0] slot_addr_o,
    output logic [MAX_MEM_ACCESS-1:0]             slot_we_o,
    output logic                                  slot_suppress_o,
    output logic                                  busy_o,
    output logic                                  err_overflow_o,
    output logic                                  err_underflow_o
);

    localparam int               PW      = $clog2(DEPTH);
    localparam int               CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);
    localparam logic [CW:0]      DEPTH_S = (CW + 1)'(DEPTH);
    localparam logic [3:0]       MAX_N   = 4'(MAX_MEM_ACCESS);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_ERROR} state_e;

    // Entry payload; completion is tracked by ucnt (responses are in order,
    // so the done entries are always the oldest cnt-ucnt entries from rp).
    logic [ADDR_W-1:0] addr_mem_q [DEPTH];
    logic              we_mem_q   [DEPTH];

    logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d, ucnt_q, ucnt_d;
    logic [CW-1:0] done_cnt, n_ext, pop_cnt;
    logic          push_req, push_ok, rsp_ok, retire_req, pop_ok;
    logic          overflow, underflow;
    logic          err_ovf_q, err_unf_q;
    state_e        state_q, state_d;

    logic [MAX_MEM_ACCESS-1:0]             slot_valid_q, slot_valid_d;
    logic [MAX_MEM_ACCESS-1:0][ADDR_W-1:0] slot_addr_q, slot_addr_d;
    logic [MAX_MEM_ACCESS-1:0]             slot_we_q, slot_we_d;
    logic                                  slot_sup_q, slot_sup_d;

    // Circular pointer advance with explicit wrap at DEPTH (DEPTH need not be a power of two)
    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [CW-1:0] k);
        logic [CW:0] s;
        s = (CW + 1)'(p) + (CW + 1)'(k);
        if (s >= DEPTH_S) s = s - DEPTH_S;
        return s[PW-1:0];
    endfunction

    // Push / completion / retire decisions, all evaluated on pre-edge state
    always_comb begin
        push_req   = obi_req_i && obi_gnt_i;
        rsp_ok     = obi_rvalid_i && (ucnt_q != '0);
        done_cnt   = cnt_q - ucnt_q + CW'(rsp_ok);
        n_ext      = CW'(rvfi_mem_cnt_i);
        retire_req = rvfi_valid_i && (rvfi_mem_cnt_i != 4'd0);
        pop_ok     = retire_req && (rvfi_mem_cnt_i <= MAX_N) && (n_ext <= done_cnt);
        underflow  = retire_req && !pop_ok;
        pop_cnt    = pop_ok ? n_ext : '0;
        push_ok    = push_req && ((cnt_q != DEPTH_C) || pop_ok);
        overflow   = push_req && !push_ok;
        cnt_d      = cnt_q - pop_cnt + CW'(push_ok);
        ucnt_d     = ucnt_q - CW'(rsp_ok) + CW'(push_ok);
        wp_d       = push_ok ? ptr_add(wp_q, CW'(1)) : wp_q;
        rp_d       = ptr_add(rp_q, pop_cnt);
    end

    // Slot contents for the next cycle; unused slots are forced to zero
    always_comb begin
        slot_valid_d = '0;
        slot_addr_d  = '0;
        slot_we_d    = '0;
        slot_sup_d   = 1'b0;
        if (pop_ok) begin
            slot_sup_d = rvfi_dbg_mode_i;
            for (int i = 0; i < MAX_MEM_ACCESS; i++) begin
                if (i < int'(rvfi_mem_cnt_i)) begin
                    slot_valid_d[i] = 1'b1;
                    slot_addr_d[i]  = addr_mem_q[ptr_add(rp_q, CW'(i))];
                    slot_we_d[i]    = we_mem_q[ptr_add(rp_q, CW'(i))];
                end
            end
        end
    end

    // Entry payload storage; needs no reset since occupancy gates every read
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            addr_mem_q[wp_q] <= obi_addr_i;
            we_mem_q[wp_q]   <= obi_we_i;
        end
    end

    // Pointers, occupancy, outstanding responses and sticky error flags
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wp_q      <= '0;
            rp_q      <= '0;
            cnt_q     <= '0;
            ucnt_q    <= '0;
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else begin
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            cnt_q     <= cnt_d;
            ucnt_q    <= ucnt_d;
            err_ovf_q <= err_ovf_q | overflow;
            err_unf_q <= err_unf_q | underflow;
        end
    end

    // Registered slot outputs: one-cycle pulse after the retiring edge
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_valid_q <= '0;
            slot_addr_q  <= '0;
            slot_we_q    <= '0;
            slot_sup_q   <= 1'b0;
        end else begin
            slot_valid_q <= slot_valid_d;
            slot_addr_q  <= slot_addr_d;
            slot_we_q    <= slot_we_d;
            slot_sup_q   <= slot_sup_d;
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // FSM next state; ERROR is sticky until reset
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (push_ok) state_d = S_ACTIVE;
            S_ACTIVE: if (cnt_d == '0) state_d = S_IDLE;
            default:  state_d = S_ERROR;
        endcase
        if (overflow || underflow) state_d = S_ERROR;
    end

    // FSM and register-driven outputs
    always_comb begin
        busy_o          = (state_q != S_IDLE) && (cnt_q != '0);
        err_overflow_o  = err_ovf_q;
        err_underflow_o = err_unf_q;
        slot_valid_o    = slot_valid_q;
        slot_addr_o     = slot_addr_q;
        slot_we_o       = slot_we_q;
        slot_suppress_o = slot_sup_q;
    end

endmodule

// File: tb/tb_uvmt_cv32e40s_sl_mem_op_sequencer.sv
// Scoreboard bench for the memory-operation sequencer: the driver updates a
// queue-based model of outstanding accesses and pushes expected slot bursts;
// a monitor compares whenever the DUT presents slots, plus flags every cycle.
module tb_uvmt_cv32e40s_sl_mem_op_sequencer;

    localparam int M  = 13;
    localparam int AW = 32;
    localparam int D  = 2*M;

    typedef logic [M*AW-1:0] wide_t;

    logic                 clk = 1'b0;
    logic                 rst_ni;
    logic                 obi_req_i, obi_gnt_i, obi_we_i, obi_rvalid_i;
    logic [AW-1:0]        obi_addr_i;
    logic                 rvfi_valid_i, rvfi_dbg_mode_i;
    logic [3:0]           rvfi_mem_cnt_i;
    logic [M-1:0]         slot_valid_o;
    logic [M-1:0][AW-1:0] slot_addr_o;
    logic [M-1:0]         slot_we_o;
    logic                 slot_suppress_o, busy_o, err_overflow_o, err_underflow_o;

    always #5 clk = ~clk;

    uvmt_cv32e40s_sl_mem_op_sequencer dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .obi_req_i       (obi_req_i),
        .obi_gnt_i       (obi_gnt_i),
        .obi_addr_i      (obi_addr_i),
        .obi_we_i        (obi_we_i),
        .obi_rvalid_i    (obi_rvalid_i),
        .rvfi_valid_i    (rvfi_valid_i),
        .rvfi_dbg_mode_i (rvfi_dbg_mode_i),
        .rvfi_mem_cnt_i  (rvfi_mem_cnt_i),
        .slot_valid_o    (slot_valid_o),
        .slot_addr_o     (slot_addr_o),
        .slot_we_o       (slot_we_o),
        .slot_suppress_o (slot_suppress_o),
        .busy_o          (busy_o),
        .err_overflow_o  (err_overflow_o),
        .err_underflow_o (err_underflow_o)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic          done;
    } ent_t;

    typedef struct {
        int                   due;
        logic [M-1:0]         valid;
        logic [M-1:0][AW-1:0] addr;
        logic [M-1:0]         we;
        logic                 sup;
    } exp_t;

    ent_t mq[$];
    exp_t exp_q[$];
    logic m_ovf = 1'b0;
    logic m_unf = 1'b0;
    int   edge_cnt = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input wide_t act, input wide_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: apply one clock edge's worth of inputs to the access queue
    task automatic model_step(input logic push, input logic [AW-1:0] a, input logic w,
                              input logic rv, input logic ret, input logic dbg, input int n);
        int   pre_size;
        bit   popped;
        bit   ok;
        exp_t e;
        popped = 0;
        if (rv) begin
            for (int i = 0; i < mq.size(); i++) begin
                if (!mq[i].done) begin
                    mq[i].done = 1'b1;
                    break;
                end
            end
        end
        pre_size = mq.size();
        if (ret && n != 0) begin
            ok = (n <= M) && (n <= mq.size());
            if (ok) for (int i = 0; i < n; i++) if (!mq[i].done) ok = 0;
            if (ok) begin
                e.due = edge_cnt + 1;
                e.valid = '0; e.addr = '0; e.we = '0; e.sup = dbg;
                for (int i = 0; i < n; i++) begin
                    e.valid[i] = 1'b1;
                    e.addr[i]  = mq[i].addr;
                    e.we[i]    = mq[i].we;
                end
                for (int i = 0; i < n; i++) void'(mq.pop_front());
                exp_q.push_back(e);
                popped = 1;
            end else begin
                m_unf = 1'b1;
            end
        end
        if (push) begin
            if (pre_size == D && !popped) m_ovf = 1'b1;
            else mq.push_back('{addr: a, we: w, done: 1'b0});
        end
    endtask

    task automatic step(input logic req, input logic gnt, input logic [AW-1:0] a, input logic w,
                        input logic rv, input logic ret, input logic dbg, input logic [3:0] n);
        @(negedge clk);
        obi_req_i = req; obi_gnt_i = gnt; obi_addr_i = a; obi_we_i = w;
        obi_rvalid_i = rv; rvfi_valid_i = ret; rvfi_dbg_mode_i = dbg; rvfi_mem_cnt_i = n;
        model_step(req && gnt, a, w, rv, ret, dbg, int'(n));
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(0, 0, '0, 0, 0, 0, 0, 4'd0);
    endtask

    task automatic grant(input logic [AW-1:0] a, input logic w, input logic rv);
        step(1, 1, a, w, rv, 0, 0, 4'd0);
    endtask

    task automatic retire(input logic [3:0] n, input logic dbg);
        step(0, 0, '0, 0, 0, 1, dbg, n);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_slot_valid"}, wide_t'(slot_valid_o), '0);
        chk({tag, "_slot_addr"}, wide_t'(slot_addr_o), '0);
        chk({tag, "_slot_we"}, wide_t'(slot_we_o), '0);
        chk({tag, "_suppress"}, wide_t'(slot_suppress_o), '0);
        chk({tag, "_busy"}, wide_t'(busy_o), '0);
        chk({tag, "_err_ovf"}, wide_t'(err_overflow_o), '0);
        chk({tag, "_err_unf"}, wide_t'(err_underflow_o), '0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_ni = 1'b0;
        obi_req_i = 0; obi_gnt_i = 0; obi_addr_i = '0; obi_we_i = 0;
        obi_rvalid_i = 0; rvfi_valid_i = 0; rvfi_dbg_mode_i = 0; rvfi_mem_cnt_i = '0;
        mq.delete(); exp_q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        #1;
        check_all_zero(tag);
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    // Monitor: pop an expected burst when due, otherwise require no slot pulse
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            edge_cnt++;
            if (exp_q.size() != 0 && exp_q[0].due == edge_cnt) begin
                e = exp_q.pop_front();
                chk("slot_valid", wide_t'(slot_valid_o), wide_t'(e.valid));
                chk("slot_addr", wide_t'(slot_addr_o), wide_t'(e.addr));
                chk("slot_we", wide_t'(slot_we_o), wide_t'(e.we));
                chk("slot_suppress", wide_t'(slot_suppress_o), wide_t'(e.sup));
            end else begin
                chk("slot_idle_valid", wide_t'(slot_valid_o), '0);
                chk("slot_idle_addr", wide_t'(slot_addr_o), '0);
            end
            chk("busy", wide_t'(busy_o), wide_t'(mq.size() != 0));
            chk("err_overflow", wide_t'(err_overflow_o), wide_t'(m_ovf));
            chk("err_underflow", wide_t'(err_underflow_o), wide_t'(m_unf));
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst_ni = 1'b0;
        obi_req_i = 0; obi_gnt_i = 0; obi_addr_i = '0; obi_we_i = 0;
        obi_rvalid_i = 0; rvfi_valid_i = 0; rvfi_dbg_mode_i = 0; rvfi_mem_cnt_i = '0;
        #2;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;

        // Single load
        grant(32'h0000_1000, 0, 0);
        step(0, 0, '0, 0, 1, 0, 0, 4'd0);
        retire(4'd1, 0);
        idle(2);

        // Five stores, responses trailing grants by one cycle
        for (int i = 0; i < 5; i++) grant(32'h2000 + 32'(4*i), 1, i > 0);
        step(0, 0, '0, 0, 1, 0, 0, 4'd0);
        retire(4'd5, 1);
        idle(2);

        // Overlap: grant in the same cycle as a two-access retire
        grant(32'h3000, 0, 0);
        grant(32'h3004, 1, 1);
        step(0, 0, '0, 0, 1, 0, 0, 4'd0);
        step(1, 1, 32'h3100, 0, 0, 1, 0, 4'd2);
        step(0, 0, '0, 0, 1, 0, 0, 4'd0);
        retire(4'd1, 0);
        idle(2);

        // Underflow: retire before the response arrives
        grant(32'h4000, 0, 0);
        retire(4'd1, 0);
        step(0, 0, '0, 0, 1, 0, 0, 4'd0);
        retire(4'd1, 0);
        idle(2);

        do_reset("rst_after_unf");

        // Overflow: 27 grants, then all responses and two 13-access retires
        for (int i = 0; i < 27; i++) grant(32'h5000 + 32'(4*i), i[0], 0);
        for (int i = 0; i < 26; i++) step(0, 0, '0, 0, 1, 0, 0, 4'd0);
        retire(4'd13, 0);
        retire(4'd13, 1);
        idle(2);

        // Reset mid-push, then late responses and an empty retire
        grant(32'h6000, 0, 0);
        grant(32'h6004, 1, 1);
        grant(32'h6008, 0, 0);
        do_reset("rst_mid_push");
        step(0, 0, '0, 0, 1, 0, 0, 4'd0);
        step(0, 0, '0, 0, 1, 0, 0, 4'd0);
        retire(4'd0, 0);
        idle(2);

        // Random traffic: error-free first, then with overflow/underflow allowed
        for (int c = 0; c < 3000; c++) begin
            logic          req, gnt, w, rv, ret, dbg;
            logic [3:0]    n;
            logic [AW-1:0] a;
            int            lead, outst, hi;
            lead = 0;
            while (lead < mq.size() && mq[lead].done) lead++;
            outst = 0;
            for (int i = 0; i < mq.size(); i++) if (!mq[i].done) outst++;
            req = ($urandom_range(0, 3) != 0);
            gnt = 1'($urandom_range(0, 1));
            if (c < 2000 && mq.size() >= D - 2) gnt = 1'b0;
            a   = $urandom;
            w   = 1'($urandom_range(0, 1));
            rv  = (outst > 0) ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 19) == 0);
            ret = ($urandom_range(0, 2) == 0);
            hi  = (lead > M) ? M : lead;
            n   = 4'($urandom_range(0, hi));
            if (c >= 2000 && $urandom_range(0, 9) == 0)
                n = 4'($urandom_range((lead + 1 > 15) ? 15 : lead + 1, 15));
            dbg = 1'($urandom_range(0, 1));
            step(req, gnt, a, w, rv, ret, dbg, n);
        end
        idle(3);

        chk("scoreboard_drain", wide_t'(exp_q.size()), '0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uvmt_cv32e40s_sl_mem_op_sequencer.md
# uvmt_cv32e40s_sl_mem_op_sequencer

Support-logic controller that sequences data-side OBI transactions into per-instruction memory-operation slots for the trigger-match checkers. It captures every granted data request into an ordered buffer and tracks response completion. When an instruction retires on RVFI, it pops that instruction's accesses and presents them as numbered slots (0..MAX_MEM_ACCESS-1). It sits between the OBI data monitor/RVFI and the per-slot load/store trigger-match instances.

## Interface
- MAX_MEM_ACCESS, 13: maximum data accesses of one instruction (push/pop worst case); slot count.
- ADDR_W, 32: address width.
- DEPTH, 2*MAX_MEM_ACCESS: buffer depth; must be a power of two or the pointers must wrap explicitly at DEPTH.
- clk_i  in  1  clock; all state on rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- obi_req_i  in  1  data OBI request.
- obi_gnt_i  in  1  data OBI grant; req&&gnt is one accepted transaction.
- obi_addr_i  in  ADDR_W  address, sampled at req&&gnt.
- obi_we_i  in  1  write enable, sampled at req&&gnt.
- obi_rvalid_i  in  1  response valid; responses return in order.
- rvfi_valid_i  in  1  instruction retire strobe.
- rvfi_dbg_mode_i  in  1  retiring instruction was in debug mode.
- rvfi_mem_cnt_i  in  4  number of data accesses of the retiring instruction (0..MAX_MEM_ACCESS).
- slot_valid_o  out  MAX_MEM_ACCESS  per-slot valid; one-cycle pulse.
- slot_addr_o  out  MAX_MEM_ACCESS x ADDR_W  per-slot address.
- slot_we_o  out  MAX_MEM_ACCESS  per-slot store flag.
- slot_suppress_o  out  1  slots belong to a debug-mode instruction; matchers must ignore.
- busy_o  out  1  buffer non-empty or responses outstanding.
- err_overflow_o  out  1  sticky: grant accepted while buffer full.
- err_underflow_o  out  1  sticky: retire requested more accesses than completed.

## Operation
- Buffer: circular, DEPTH entries {addr, we, done}; write pointer wp, read pointer rp, occupancy cnt (0..DEPTH), all wrapping modulo DEPTH.
- Push: on req&&gnt write {addr, we, done=0} at wp; wp++, cnt++.
- Completion: resp pointer cp (oldest not-done entry); on rvalid set done[cp], cp++. A rvalid with no un-done entry is ignored; it does not raise an error.
- Retire: on rvfi_valid_i with n=rvfi_mem_cnt_i:
  - If n=0, no pop and no slot output.
  - Otherwise, if the first n entries from rp are all done (including an rvalid in the same cycle), load slots 0..n-1 from entries rp..rp+n-1, pulse slot_valid_o[n-1:0], rp+=n, cnt-=n.
  - Otherwise set err_underflow_o and pop nothing.
  - n>MAX_MEM_ACCESS is treated as underflow.
- Simultaneous push and retire in the same cycle: the pop is evaluated on pre-push state and cnt updates by +1-n. A pushed entry is never part of the same-cycle retire.
- Full: a push with cnt==DEPTH and no same-cycle pop sets err_overflow_o and drops the request; pointers are unchanged.
- State machine: IDLE (cnt==0, nothing outstanding) -> ACTIVE on push; ACTIVE -> IDLE when cnt returns to 0; any state -> ERROR on overflow/underflow. ERROR is sticky until reset; push/pop/retire continue normally in ERROR so that later matches remain observable.
- busy_o = state!=IDLE && cnt!=0.

## Timing
- Reset: all pointers, cnt, done bits = 0; state IDLE; slot_valid_o = 0, slot_addr_o = 0, slot_we_o = 0, slot_suppress_o = 0, busy_o = 0, both error flags = 0.
- Asynchronous reset mid-transaction discards all entries and outstanding responses immediately. Responses arriving after reset release are ignored because no entries are un-done.
- Slot outputs are registered: a retire at edge k produces slot_valid_o during cycle k+1 only. Unused slots are 0 and hold no stale data.
- slot_suppress_o is registered with the slots and equals rvfi_dbg_mode_i sampled at retire.
- Error flags assert the cycle after the offending edge.
- Throughput: one push, one completion and one retire per cycle, concurrently.

## Test plan
- Single load at 0x0000_1000: grant, rvalid, retire with n=1 -> next cycle slot_valid_o=13'h0001, slot_addr_o[0]=0x1000, slot_we_o[0]=0; busy_o then 0.
- Push of 5 stores at 0x2000..0x2010 step 4: 5 grants and 5 rvalids, retire with n=5 -> slot_valid_o=13'h001F, addresses in order, slot_we_o=13'h001F.
- Overlap: next instruction's grant arrives in the same cycle as a retire with n=2 -> 2 slots output; the new entry remains (cnt=1); the following retire with n=1 shows it in slot 0.
- Underflow: grant without rvalid, then retire with n=1 -> err_underflow_o=1 next cycle, no slot pulse, cnt stays 1.
- Overflow: 27 grants with no retire -> err_overflow_o=1 at the 27th; cnt=26; a later retire with n=13 after all rvalids outputs the first 13 addresses.
- Reset mid-push: 3 grants, 1 rvalid, assert rst_ni=0 -> all outputs 0 immediately; after release, 2 late rvalids then a retire with n=0 -> no error and busy_o=0.
